// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive datapath.
//   ETH_DATA_WIDTH : byte-wide stream width
//   eth_word_t     : buffered beat, {last, data}
package eth_pkg;

    localparam int unsigned ETH_DATA_WIDTH = 8;

    typedef struct packed {
        logic                      last;
        logic [ETH_DATA_WIDTH-1:0] data;
    } eth_word_t;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data written on the edge
//   rd_en   : read strobe, rd_data updates on the edge and holds otherwise
//   rd_addr : read address
// Contents are not reset.
module eth_sdp_ram #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Registered read; rd_data holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_eth_rx_drop_fifo.sv
// Store-and-forward frame FIFO behind the GMII receiver. Frames are released
// only once fully stored and good; bad (tuser) or overflowing frames are
// dropped whole.
//   clk, rst_n              : clock, asynchronous active-low reset
//   s_axis_*                : receiver stream (no tready, never stalls)
//   m_axis_*                : backpressured output stream
//   status_good_frame       : pulse, frame committed
//   status_bad_frame        : pulse, frame dropped on tuser
//   status_overflow         : pulse, frame dropped because the buffer filled
module axis_eth_rx_drop_fifo
    import eth_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  status_good_frame,
    output logic                  status_bad_frame,
    output logic                  status_overflow
);

    localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned WORD_W = $bits(eth_word_t);

    if (DATA_WIDTH != ETH_DATA_WIDTH) begin : g_bad_data_width
        $error("axis_eth_rx_drop_fifo: DATA_WIDTH must be 8");
    end
    if (ADDR_WIDTH < 4 || ADDR_WIDTH > 16) begin : g_bad_addr_width
        $error("axis_eth_rx_drop_fifo: ADDR_WIDTH must be in 4..16");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_commit;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fill;
    logic             drop_flag;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;
    logic             s1_valid;
    logic             s2_load;
    eth_word_t        wr_word;
    eth_word_t        rd_word;

    assign fill    = wr_ptr - rd_ptr;
    assign full    = (fill == PTR_W'(DEPTH));
    assign empty   = (rd_ptr == wr_commit);
    assign wr_en   = s_axis_tvalid && !drop_flag && !full;
    // Stage 2 takes stage 1 when the output register is empty or draining.
    assign s2_load = s1_valid && (!m_axis_tvalid || m_axis_tready);
    // Stage 1 reads when it is empty or handing its word on this cycle.
    assign rd_en   = !empty && (!s1_valid || s2_load);
    assign wr_word = '{last: s_axis_tlast, data: s_axis_tdata};

    eth_sdp_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_word)
    );

    // Write side: store, commit, or roll back the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr            <= '0;
            wr_commit         <= '0;
            drop_flag         <= 1'b0;
            status_good_frame <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_overflow   <= 1'b0;
        end else begin
            status_good_frame <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_overflow   <= 1'b0;
            if (s_axis_tvalid) begin
                if (drop_flag) begin
                    if (s_axis_tlast) begin
                        status_overflow <= 1'b1;
                        wr_ptr          <= wr_commit;
                        drop_flag       <= 1'b0;
                    end
                end else if (full) begin
                    wr_ptr <= wr_commit;
                    if (s_axis_tlast) begin
                        status_overflow <= 1'b1;
                    end else begin
                        drop_flag <= 1'b1;
                    end
                end else if (s_axis_tlast) begin
                    if (s_axis_tuser) begin
                        wr_ptr           <= wr_commit;
                        status_bad_frame <= 1'b1;
                    end else begin
                        wr_ptr            <= wr_ptr + PTR_W'(1);
                        wr_commit         <= wr_ptr + PTR_W'(1);
                        status_good_frame <= 1'b1;
                    end
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Read side: RAM read stage feeding the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            s1_valid      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= rd_word.data;
                m_axis_tlast  <= rd_word.last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
